// File: rtl/cs_window_sched_if.sv
// Sample-in / result-out handshake bundle for the sliding-window smoother.
// The producer/consumer side uses master; the scheduler uses slave.
interface cs_window_sched_if #(
    parameter int DW = 8,
    parameter int YW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] X;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] Y;

    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, Y
    );

    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, Y
    );
endinterface

// File: rtl/cs_window_sched.sv
// 9-sample window scheduler: Y = floor((sum + 9*x_appr)/8), where x_appr is the
// largest window sample not exceeding floor(sum/9), found by a 9-cycle buffer scan.
module cs_window_sched #(
    parameter int DW = 8,
    parameter int SW = 12,
    parameter int YW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    cs_window_sched_if.slave  bus
);
    localparam int N = 9;

    typedef enum logic [2:0] {
        ST_FILL = 3'd0,
        ST_IDLE = 3'd1,
        ST_AVG  = 3'd2,
        ST_SCAN = 3'd3,
        ST_CALC = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_buf [0:N-1];
    logic [3:0]    r_wptr;
    logic [3:0]    r_fill;
    logic [3:0]    r_idx;
    logic [SW-1:0] r_sum;
    logic [DW-1:0] r_avg;
    logic [DW-1:0] r_best;
    logic [YW-1:0] r_y;
    logic          r_out_valid;
    logic          r_in_ready;

    logic          w_accept;
    logic          w_flush;
    logic [DW-1:0] w_old;
    logic [DW-1:0] w_entry;
    logic [SW:0]   w_acc;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Y         = r_y;

    // Handshake qualification, evicted sample, scan read and result accumulator.
    always_comb begin
        w_flush  = (~reset) | clr;
        w_accept = bus.in_valid & r_in_ready;
        w_entry  = r_buf[r_idx];
        // Slots are not yet part of the window while filling, so they subtract nothing.
        if (r_state == ST_FILL) begin
            w_old = '0;
        end else begin
            w_old = r_buf[r_wptr];
        end
        w_acc = {1'b0, r_sum} + ((SW+1)'(r_best) * (SW+1)'(4'd9));
    end

    // Circular sample storage; contents are don't-care after a flush.
    always_ff @(posedge clk) begin
        if (!w_flush && w_accept) begin
            r_buf[r_wptr] <= bus.X;
        end
    end

    // Scheduler FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state     <= ST_FILL;
            r_wptr      <= 4'd0;
            r_fill      <= 4'd0;
            r_idx       <= 4'd0;
            r_sum       <= '0;
            r_avg       <= '0;
            r_best      <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_FILL, ST_IDLE: begin
                    if (w_accept) begin
                        r_sum  <= r_sum + SW'(bus.X) - SW'(w_old);
                        r_wptr <= (r_wptr == 4'd8) ? 4'd0 : (r_wptr + 4'd1);
                        if ((r_state == ST_IDLE) || (r_fill == 4'd8)) begin
                            r_state    <= ST_AVG;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_fill <= r_fill + 4'd1;
                        end
                    end
                end
                ST_AVG: begin
                    r_avg   <= DW'(r_sum / SW'(4'd9));
                    r_best  <= '0;
                    r_idx   <= 4'd0;
                    r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if ((w_entry <= r_avg) && (w_entry > r_best)) begin
                        r_best <= w_entry;
                    end
                    if (r_idx == 4'd8) begin
                        r_state <= ST_CALC;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                ST_CALC: begin
                    r_y     <= YW'(w_acc >> 2'd3);
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    // Y settles one cycle ahead of out_valid so it is stable for the whole offer.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_FILL;
                    r_wptr      <= 4'd0;
                    r_fill      <= 4'd0;
                    r_sum       <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cs_window_sched.sv
// Bench for cs_window_sched: directed scenarios with literal results plus randomized
// traffic, all checked every cycle against a queue-based window model.
module tb_cs_window_sched;
    localparam int DW = 8;
    localparam int SW = 12;
    localparam int YW = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clr = 1'b0;

    cs_window_sched_if #(.DW(DW), .YW(YW)) bus();

    cs_window_sched #(.DW(DW), .SW(SW), .YW(YW)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int acc_edge = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Window model: last 9 accepted samples since flush, plus a busy/timer view of the result path.
    int win_q[$];
    int m_cnt = 0;
    bit m_ok = 1'b0;
    bit m_busy = 1'b0;
    bit m_ov = 1'b0;
    int m_cyc = 0;
    int m_exp_y = 0;
    int m_last_y = 0;
    int m_results = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ref_y();
        int s = 0;
        int a;
        int b = 0;
        foreach (win_q[i]) s += win_q[i];
        a = s / 9;
        foreach (win_q[i]) if (win_q[i] <= a && win_q[i] > b) b = win_q[i];
        return (s + 9 * b) / 8;
    endfunction

    // Compare the DUT with the model, then advance the model across the next rising edge.
    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            check("in_ready", int'(bus.in_ready), int'(!m_busy));
            check("out_valid", int'(bus.out_valid), int'(m_ov));
            if (m_ov) check("y_result", int'(bus.Y), m_exp_y);
            else if (!m_busy) check("y_retained", int'(bus.Y), m_last_y);
        end
        if (!reset || clr) begin
            if (!reset) m_ok = 1'b1;
            win_q.delete();
            m_cnt = 0;
            m_busy = 1'b0;
            m_ov = 1'b0;
            m_cyc = 0;
            m_last_y = 0;
        end else if (m_busy) begin
            if (m_ov && bus.out_ready) begin
                m_ov = 1'b0;
                m_busy = 1'b0;
                m_last_y = m_exp_y;
                m_results++;
            end else begin
                m_cyc++;
                if (m_cyc == 12) m_ov = 1'b1;
            end
        end else if (bus.in_valid) begin
            win_q.push_back(int'(bus.X));
            if (win_q.size() > 9) void'(win_q.pop_front());
            m_cnt++;
            if (m_cnt >= 9) begin
                m_busy = 1'b1;
                m_cyc = 0;
                m_exp_y = ref_y();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic feed(input int v);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.X = DW'(v);
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                acc_edge = edge_cnt + 1;
                step();
                got = 1'b1;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("feed_accepted", int'(got), 1);
    endtask

    task automatic expect_out(input string name, input int lit);
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check({name, "_seen"}, int'(got), 1);
        if (got) begin
            check(name, int'(bus.Y), lit);
            check({name, "_latency"}, edge_cnt - acc_edge, 12);
            check({name, "_model"}, m_exp_y, lit);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.X = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        check("reset_y", int'(bus.Y), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);

        for (int v = 1; v <= 9; v++) feed(v);
        expect_out("ramp_1_9", 11);
        step();
        feed(10);
        expect_out("ramp_2_10", 13);
        step();

        do_reset();
        for (int i = 0; i < 8; i++) feed(0);
        feed(90);
        expect_out("zeros_90", 11);
        step();

        do_reset();
        for (int i = 0; i < 9; i++) feed(255);
        expect_out("all_255", 573);
        step();

        // Backpressure: result held, producer stalled, then released.
        do_reset();
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 9; v++) feed(v);
        expect_out("hold_result", 11);
        bus.in_valid = 1'b1;
        bus.X = 8'd77;
        for (int i = 0; i < 20; i++) begin
            check("hold_y", int'(bus.Y), 11);
            check("hold_in_ready", int'(bus.in_ready), 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("release_out_valid", int'(bus.out_valid), 0);
        check("release_in_ready", int'(bus.in_ready), 1);
        feed(77);
        expect_out("after_hold", 25);
        step();

        // Abort mid-scan with reset, then with clr.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int v = 1; v <= 9; v++) feed(v);
            repeat (5) step();
            if (k == 0) do_reset();
            else do_clr();
            check("abort_y", int'(bus.Y), 0);
            check("abort_in_ready", int'(bus.in_ready), 1);
            for (int i = 0; i < 8; i++) feed(9);
            for (int i = 0; i < 20; i++) begin
                check("abort_no_valid", int'(bus.out_valid), 0);
                step();
            end
            feed(9);
            expect_out("abort_refill", 20);
            step();
        end

        // A sample offered alongside clr is dropped.
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.X = 8'd200;
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) feed(4);
        expect_out("clr_drop", 9);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            bus.X = DW'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            clr = ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0;
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end
        reset = 1'b1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) step();
        check("random_results_seen", int'(m_results > 10), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
